// File: rtl/deser_s2p_pkg.sv
// Shared constants and types for the four-lane serial-to-parallel receiver.
//   LANES / BYTE_W       : lane count and reassembled word width
//   COM_DEFAULT          : alignment symbol hunted on lane 0
//   COM_COUNT_DEFAULT    : consecutive byte-aligned COMs needed for lock
//   state_t              : alignment FSM states
package deser_s2p_pkg;

  localparam int unsigned LANES             = 4;
  localparam int unsigned BYTE_W            = 8;
  localparam logic [7:0]  COM_DEFAULT       = 8'hBC;
  localparam int unsigned COM_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

endpackage

// File: rtl/deser_s2p_lane.sv
// One receive lane: MSB-first shift register plus a held output byte.
//   CLK       : bit clock
//   reset     : synchronous active-high reset, clears both registers
//   ENB       : 0 freezes the lane and ignores bit_in
//   bit_in    : serial input bit for this lane
//   load      : capture the completed word into data_byte this cycle
//   data_byte : last reassembled byte, held between loads
//   word      : next-word view {sr[6:0], bit_in}, used for COM detection
module s2p_lane
  import deser_s2p_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              ENB,
  input  logic              bit_in,
  input  logic              load,
  output logic [BYTE_W-1:0] data_byte,
  output logic [BYTE_W-1:0] word
);

  logic [BYTE_W-1:0] sr;

  assign word = {sr[BYTE_W-2:0], bit_in};

  always_ff @(posedge CLK) begin
    if (reset) begin
      sr        <= '0;
      data_byte <= '0;
    end else if (ENB) begin
      sr <= word;
      if (load) begin
        data_byte <= word;
      end
    end
  end

endmodule

// File: rtl/deser_s2p.sv
// Four-lane serial-to-parallel receiver. Hunts for COM on lane 0 with a
// sliding window, confirms COM_COUNT byte-aligned COMs, then emits one byte
// per lane every 8 enabled cycles with a one-cycle valid strobe.
//   CLK      : bit clock
//   reset    : synchronous active-high reset
//   ENB      : 0 holds all state, forces valid low
//   data_in  : one serial bit per lane, [n] = lane n
//   Q0..Q3   : reassembled bytes for lanes 0..3
//   valid    : one-cycle pulse when Q0..Q3 update
//   active   : alignment lock achieved
module deser_s2p
  import deser_s2p_pkg::*;
#(
  parameter logic [7:0]  COM       = COM_DEFAULT,
  parameter int unsigned COM_COUNT = COM_COUNT_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ENB,
  input  logic [LANES-1:0] data_in,
  output logic [7:0]       Q0,
  output logic [7:0]       Q1,
  output logic [7:0]       Q2,
  output logic [7:0]       Q3,
  output logic             valid,
  output logic             active
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  com_cnt, com_cnt_n;
  logic        valid_n;
  logic        load;
  logic        com_hit;

  logic [BYTE_W-1:0] q    [LANES];
  logic [BYTE_W-1:0] word [LANES];

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    s2p_lane u_lane (
      .CLK       (CLK),
      .reset     (reset),
      .ENB       (ENB),
      .bit_in    (data_in[n]),
      .load      (load),
      .data_byte (q[n]),
      .word      (word[n])
    );
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];

  // Only lane 0 drives alignment; the other lanes' word taps are not needed.
  logic unused_words;
  assign unused_words = ^{word[1], word[2], word[3]};

  assign com_hit = (word[0] == COM);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= SEARCH;
      bit_cnt <= '0;
      com_cnt <= '0;
      valid   <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      com_cnt <= com_cnt_n;
      valid   <= valid_n;
      active  <= (state_n == ACTIVE);
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    com_cnt_n = com_cnt;
    valid_n   = 1'b0;
    load      = 1'b0;
    if (ENB) begin
      unique case (state)
        SEARCH: begin
          if (com_hit) begin
            bit_cnt_n = '0;
            com_cnt_n = 4'd1;
            state_n   = (COM_TARGET == 4'd1) ? ACTIVE : LOCKING;
          end
        end
        LOCKING: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (com_hit) begin
              com_cnt_n = com_cnt + 4'd1;
              if (com_cnt_n == COM_TARGET) begin
                state_n = ACTIVE;
              end
            end else begin
              com_cnt_n = '0;
              state_n   = SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            load    = 1'b1;
            valid_n = 1'b1;
          end
        end
        default: begin
          state_n = SEARCH;
        end
      endcase
    end
  end

endmodule
